// File: rtl/branch_unit.sv
// -----------------------------------------------------------------------------
// branch_unit
// Registered branch resolution unit. Keeps the architectural Z/C/N/V flag
// register, evaluates the 16 condition codes on the effective flags (a flag
// write in the acceptance cycle is bypassed into the evaluation), computes
// the PC-relative or register-indirect target, produces a one-cycle result
// pulse one cycle after acceptance and holds a pipeline flush for
// FLUSH_CYCLES cycles after every taken branch. Branch statistics saturate.
//
// Ports:
//   clk, rst_n                 clock, synchronous active-low reset
//   flag_we[3:0], flag_in[3:0] per-flag write ([0]=Z [1]=C [2]=N [3]=V)
//   br_valid / br_ready        request handshake
//   br_cond, br_pc, br_offset,
//   br_indirect, br_reg_target request payload
//   res_valid, res_taken,
//   res_target, res_link       registered result (held between pulses)
//   flush                      squash younger stages
//   flags_q                    current flag register
//   branch_cnt, taken_cnt      saturating statistics
// -----------------------------------------------------------------------------
module branch_unit #(
  parameter int PC_W         = 16,
  parameter int OFF_W        = 8,
  parameter int FLUSH_CYCLES = 2,
  parameter int CNT_W        = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [3:0]        flag_we,
  input  logic [3:0]        flag_in,
  input  logic              br_valid,
  output logic              br_ready,
  input  logic [3:0]        br_cond,
  input  logic [PC_W-1:0]   br_pc,
  input  logic [OFF_W-1:0]  br_offset,
  input  logic              br_indirect,
  input  logic [PC_W-1:0]   br_reg_target,
  output logic              res_valid,
  output logic              res_taken,
  output logic [PC_W-1:0]   res_target,
  output logic [PC_W-1:0]   res_link,
  output logic              flush,
  output logic [3:0]        flags_q,
  output logic [CNT_W-1:0]  branch_cnt,
  output logic [CNT_W-1:0]  taken_cnt
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RESOLVE = 2'd1,
    ST_FLUSH   = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [3:0]         flags_d;
  logic [3:0]         fcnt_q, fcnt_d;
  logic               br_ready_q, br_ready_d;
  logic               res_valid_q, res_valid_d;
  logic               res_taken_q, res_taken_d;
  logic [PC_W-1:0]    res_target_q, res_target_d;
  logic [PC_W-1:0]    res_link_q, res_link_d;
  logic               flush_q, flush_d;
  logic [CNT_W-1:0]   branch_cnt_q, branch_cnt_d;
  logic [CNT_W-1:0]   taken_cnt_q, taken_cnt_d;

  logic signed [OFF_W-1:0] off_s;
  logic [PC_W-1:0]    seq_s;
  logic [PC_W-1:0]    rel_s;
  logic               cond_ok_s;

  // Condition-code table evaluated on {V,N,C,Z}.
  function automatic logic cond_eval(input logic [3:0] cond, input logic [3:0] f);
    logic z, c, n, v;
    z = f[0];
    c = f[1];
    n = f[2];
    v = f[3];
    case (cond)
      4'd0:    cond_eval = z;
      4'd1:    cond_eval = ~z;
      4'd2:    cond_eval = c;
      4'd3:    cond_eval = ~c;
      4'd4:    cond_eval = n;
      4'd5:    cond_eval = ~n;
      4'd6:    cond_eval = v;
      4'd7:    cond_eval = ~v;
      4'd8:    cond_eval = c & ~z;
      4'd9:    cond_eval = ~c | z;
      4'd10:   cond_eval = (n == v);
      4'd11:   cond_eval = (n != v);
      4'd12:   cond_eval = ~z & (n == v);
      4'd13:   cond_eval = z | (n != v);
      4'd14:   cond_eval = 1'b1;
      4'd15:   cond_eval = 1'b0;
      default: cond_eval = 1'b0;
    endcase
  endfunction

  assign off_s = $signed(br_offset);

  // Datapath: effective flags (bypass), sequential and relative targets.
  always_comb begin
    flags_d   = (flags_q & ~flag_we) | (flag_in & flag_we);
    seq_s     = br_pc + PC_W'(1'b1);
    // Size cast of a signed operand sign-extends the offset; wrap is silent.
    rel_s     = seq_s + PC_W'(off_s);
    // The next flag value is exactly the effective flag set for this cycle.
    cond_ok_s = cond_eval(br_cond, flags_d);
  end

  // Next-state, result capture, flush counter and statistics.
  always_comb begin
    state_d      = state_q;
    fcnt_d       = fcnt_q;
    res_taken_d  = res_taken_q;
    res_target_d = res_target_q;
    res_link_d   = res_link_q;
    branch_cnt_d = branch_cnt_q;
    taken_cnt_d  = taken_cnt_q;

    case (state_q)
      ST_IDLE: begin
        if (br_valid) begin
          state_d      = ST_RESOLVE;
          res_taken_d  = cond_ok_s;
          res_target_d = cond_ok_s ? (br_indirect ? br_reg_target : rel_s) : seq_s;
          res_link_d   = seq_s;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RESOLVE: begin
        if (branch_cnt_q != {CNT_W{1'b1}}) begin
          branch_cnt_d = branch_cnt_q + CNT_W'(1'b1);
        end else begin
          branch_cnt_d = branch_cnt_q;
        end
        if (res_taken_q && (taken_cnt_q != {CNT_W{1'b1}})) begin
          taken_cnt_d = taken_cnt_q + CNT_W'(1'b1);
        end else begin
          taken_cnt_d = taken_cnt_q;
        end
        if (res_taken_q) begin
          state_d = ST_FLUSH;
          fcnt_d  = 4'(FLUSH_CYCLES);
        end else begin
          state_d = ST_IDLE;
          fcnt_d  = 4'd0;
        end
      end
      ST_FLUSH: begin
        if (fcnt_q <= 4'd1) begin
          state_d = ST_IDLE;
          fcnt_d  = 4'd0;
        end else begin
          state_d = ST_FLUSH;
          fcnt_d  = fcnt_q - 4'd1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        fcnt_d  = 4'd0;
      end
    endcase

    // Handshake/status outputs are registered from the next state.
    res_valid_d = (state_d == ST_RESOLVE);
    flush_d     = (state_d == ST_FLUSH);
    br_ready_d  = (state_d == ST_IDLE);
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      fcnt_q       <= 4'd0;
      flags_q      <= 4'd0;
      br_ready_q   <= 1'b1;
      res_valid_q  <= 1'b0;
      res_taken_q  <= 1'b0;
      res_target_q <= {PC_W{1'b0}};
      res_link_q   <= {PC_W{1'b0}};
      flush_q      <= 1'b0;
      branch_cnt_q <= {CNT_W{1'b0}};
      taken_cnt_q  <= {CNT_W{1'b0}};
    end else begin
      state_q      <= state_d;
      fcnt_q       <= fcnt_d;
      flags_q      <= flags_d;
      br_ready_q   <= br_ready_d;
      res_valid_q  <= res_valid_d;
      res_taken_q  <= res_taken_d;
      res_target_q <= res_target_d;
      res_link_q   <= res_link_d;
      flush_q      <= flush_d;
      branch_cnt_q <= branch_cnt_d;
      taken_cnt_q  <= taken_cnt_d;
    end
  end

  assign br_ready   = br_ready_q;
  assign res_valid  = res_valid_q;
  assign res_taken  = res_taken_q;
  assign res_target = res_target_q;
  assign res_link   = res_link_q;
  assign flush      = flush_q;
  assign branch_cnt = branch_cnt_q;
  assign taken_cnt  = taken_cnt_q;

endmodule

// File: tb/tb_branch_unit.sv
// -----------------------------------------------------------------------------
// tb_branch_unit
// Two instances share one stimulus stream: the default configuration and a
// CNT_W=2 copy whose counters saturate quickly. Expected values come from a
// transaction-level model (flag word, pair/invert condition rule, integer
// target arithmetic, plain integer branch counts clamped at the maximum).
// -----------------------------------------------------------------------------
module tb_branch_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  flag_we, flag_in;
  logic        br_valid;
  logic [3:0]  br_cond;
  logic [15:0] br_pc;
  logic [7:0]  br_offset;
  logic        br_indirect;
  logic [15:0] br_reg_target;

  logic        br_ready, res_valid, res_taken, flush;
  logic [15:0] res_target, res_link, branch_cnt, taken_cnt;
  logic [3:0]  flags_q;

  logic        s_br_ready, s_res_valid, s_res_taken, s_flush;
  logic [15:0] s_res_target, s_res_link;
  logic [1:0]  s_branch_cnt, s_taken_cnt;
  logic [3:0]  s_flags_q;

  int n_checks = 0;
  int n_pass   = 0;
  logic [3:0] m_flags = 4'd0;
  int m_br = 0;
  int m_tk = 0;
  bit rand_flags = 1'b0;

  always #5 clk = ~clk;

  branch_unit dut (
    .clk(clk), .rst_n(rst_n), .flag_we(flag_we), .flag_in(flag_in),
    .br_valid(br_valid), .br_ready(br_ready), .br_cond(br_cond), .br_pc(br_pc),
    .br_offset(br_offset), .br_indirect(br_indirect), .br_reg_target(br_reg_target),
    .res_valid(res_valid), .res_taken(res_taken), .res_target(res_target),
    .res_link(res_link), .flush(flush), .flags_q(flags_q),
    .branch_cnt(branch_cnt), .taken_cnt(taken_cnt)
  );

  branch_unit #(.CNT_W(2)) dut_sat (
    .clk(clk), .rst_n(rst_n), .flag_we(flag_we), .flag_in(flag_in),
    .br_valid(br_valid), .br_ready(s_br_ready), .br_cond(br_cond), .br_pc(br_pc),
    .br_offset(br_offset), .br_indirect(br_indirect), .br_reg_target(br_reg_target),
    .res_valid(s_res_valid), .res_taken(s_res_taken), .res_target(s_res_target),
    .res_link(s_res_link), .flush(s_flush), .flags_q(s_flags_q),
    .branch_cnt(s_branch_cnt), .taken_cnt(s_taken_cnt)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
  endtask

  // Reference condition rule: odd codes are the negation of the even code below.
  function automatic bit ref_cond(input logic [3:0] c, input logic [3:0] f);
    bit z, cy, n, v, base;
    z = f[0]; cy = f[1]; n = f[2]; v = f[3];
    case (c[3:1])
      3'd0: base = z;
      3'd1: base = cy;
      3'd2: base = n;
      3'd3: base = v;
      3'd4: base = cy && !z;
      3'd5: base = (n == v);
      3'd6: base = !z && (n == v);
      default: base = 1'b1;
    endcase
    return c[0] ? !base : base;
  endfunction

  function automatic int clamp(input int x, input int mx);
    return (x > mx) ? mx : x;
  endfunction

  // One clock: update the flag model from what is being driven, then sample.
  task automatic tick();
    if (!rst_n) m_flags = 4'd0;
    else m_flags = (m_flags & ~flag_we) | (flag_in & flag_we);
    @(negedge clk);
    check("flags", 32'(flags_q), 32'(m_flags));
    check("flags_sat", 32'(s_flags_q), 32'(m_flags));
  endtask

  task automatic check_counts(input string tag);
    check({tag, "_bcnt"}, 32'(branch_cnt), 32'(clamp(m_br, 65535)));
    check({tag, "_tcnt"}, 32'(taken_cnt), 32'(clamp(m_tk, 65535)));
    check({tag, "_bcnt_sat"}, 32'(s_branch_cnt), 32'(clamp(m_br, 3)));
    check({tag, "_tcnt_sat"}, 32'(s_taken_cnt), 32'(clamp(m_tk, 3)));
  endtask

  // Issue one branch and check its complete result/flush sequence.
  task automatic branch(input logic [3:0] we, input logic [3:0] fin, input logic [3:0] cond,
                        input logic [15:0] pc, input logic [7:0] off, input logic ind,
                        input logic [15:0] rt, input bit hold);
    logic [3:0]  ef;
    bit          tk;
    int          so;
    logic [15:0] seq, exp_t;
    int          guard;
    guard = 0;
    while (!br_ready && guard < 20) begin
      br_valid = 1'b0; flag_we = 4'd0;
      tick();
      guard++;
    end
    check("ready_wait", 32'(br_ready), 32'(1'b1));
    ef    = (m_flags & ~we) | (fin & we);
    tk    = ref_cond(cond, ef);
    so    = off[7] ? int'(off) - 256 : int'(off);
    seq   = 16'((int'(pc) + 1) & 32'hFFFF);
    exp_t = tk ? (ind ? rt : 16'((int'(pc) + 1 + so) & 32'hFFFF)) : seq;
    br_valid = 1'b1; flag_we = we; flag_in = fin; br_cond = cond;
    br_pc = pc; br_offset = off; br_indirect = ind; br_reg_target = rt;
    tick();
    if (!hold) br_valid = 1'b0;
    flag_we = rand_flags ? 4'($urandom) : 4'd0;
    flag_in = 4'($urandom);
    check("res_valid", 32'(res_valid), 32'(1'b1));
    check("res_taken", 32'(res_taken), 32'(tk));
    check("res_target", 32'(res_target), 32'(exp_t));
    check("res_link", 32'(res_link), 32'(seq));
    check("resolve_ready", 32'(br_ready), 32'(1'b0));
    check("resolve_flush", 32'(flush), 32'(1'b0));
    check("sat_res", {s_res_valid, s_res_taken, s_res_target}, {1'b1, tk, exp_t});
    m_br++;
    if (tk) m_tk++;
    for (int i = 0; i < (tk ? 2 : 0); i++) begin
      tick();
      flag_we = rand_flags ? 4'($urandom) : 4'd0;
      flag_in = 4'($urandom);
      check("flush_on", 32'(flush), 32'(1'b1));
      check("flush_ready", 32'(br_ready), 32'(1'b0));
      check("flush_no_res", 32'(res_valid), 32'(1'b0));
      check("sat_flush", {s_flush, s_br_ready}, {1'b1, 1'b0});
    end
    tick();
    br_valid = 1'b0;
    flag_we  = 4'd0;
    check("done_ready", 32'(br_ready), 32'(1'b1));
    check("done_flush", 32'(flush), 32'(1'b0));
    check("done_no_res", 32'(res_valid), 32'(1'b0));
    check("hold_target", 32'(res_target), 32'(exp_t));
    check("hold_link", {res_link, res_taken}, {seq, tk});
    check("sat_done", {s_br_ready, s_flush, s_res_valid}, {1'b1, 1'b0, 1'b0});
    check_counts("done");
  endtask

  initial begin
    rst_n = 1'b0; flag_we = 4'd0; flag_in = 4'd0; br_valid = 1'b0; br_cond = 4'd0;
    br_pc = 16'd0; br_offset = 8'd0; br_indirect = 1'b0; br_reg_target = 16'd0;
    tick();
    tick();
    check("rst_ready", 32'(br_ready), 32'(1'b1));
    check("rst_res", {res_valid, res_taken, res_target, res_link}, 32'd0);
    check("rst_flush", 32'(flush), 32'(1'b0));
    check_counts("rst");
    rst_n = 1'b1;
    tick();

    // AL, negative offset: target 0x000F, link 0x0011.
    branch(4'd0, 4'd0, 4'd14, 16'h0010, 8'hFE, 1'b0, 16'h0000, 1'b0);
    // EQ without bypass (Z=0) is not taken, then with a same-cycle Z write it is.
    branch(4'd0, 4'd0, 4'd0, 16'h0200, 8'h10, 1'b0, 16'h0000, 1'b0);
    branch(4'b0001, 4'b0001, 4'd0, 16'h0200, 8'h10, 1'b0, 16'h0000, 1'b0);

    // All 16 flag values against all 16 codes, flags written via bypass.
    for (int f = 0; f < 16; f++)
      for (int c = 0; c < 16; c++)
        branch(4'hF, 4'(f), 4'(c), 16'($urandom), 8'($urandom), 1'($urandom),
               16'($urandom), 1'b0);

    // PC wrap, and indirect with NV.
    branch(4'd0, 4'd0, 4'd14, 16'hFFFF, 8'h01, 1'b0, 16'h0000, 1'b0);
    branch(4'd0, 4'd0, 4'd15, 16'hFFFF, 8'h01, 1'b1, 16'h1234, 1'b0);
    branch(4'd0, 4'd0, 4'd14, 16'h4000, 8'h05, 1'b1, 16'h1234, 1'b0);

    // Reset during the first flush cycle.
    br_valid = 1'b1; br_cond = 4'd14; br_pc = 16'h0100; br_offset = 8'd0; br_indirect = 1'b0;
    tick();
    br_valid = 1'b0;
    check("mid_res_valid", 32'(res_valid), 32'(1'b1));
    tick();
    check("mid_flush_on", 32'(flush), 32'(1'b1));
    rst_n = 1'b0;
    tick();
    m_br = 0; m_tk = 0;
    check("mid_rst_flush", 32'(flush), 32'(1'b0));
    check("mid_rst_ready", 32'(br_ready), 32'(1'b1));
    check("mid_rst_res", 32'(res_valid), 32'(1'b0));
    check_counts("mid_rst");
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("post_rst_quiet", {res_valid, flush, br_ready}, {1'b0, 1'b0, 1'b1});
    end

    // Five taken branches with br_valid held through resolve/flush.
    for (int i = 0; i < 5; i++)
      branch(4'd0, 4'd0, 4'd14, 16'($urandom), 8'($urandom), 1'b0, 16'd0, 1'b1);
    check("sat_bcnt5", 32'(s_branch_cnt), 32'd3);
    check("sat_tcnt5", 32'(s_taken_cnt), 32'd3);
    check("bcnt5", 32'(branch_cnt), 32'd5);

    // Random traffic with background flag writes.
    rand_flags = 1'b1;
    for (int i = 0; i < 300; i++)
      branch(4'($urandom), 4'($urandom), 4'($urandom), 16'($urandom), 8'($urandom),
             1'($urandom), 16'($urandom), 1'($urandom));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
